// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch unit.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP          = 4;

  // True when the low address bits select a whole instruction word.
  function automatic logic word_aligned(input logic [1:0] lo);
    return (lo == 2'b00);
  endfunction

endpackage

// File: rtl/pc_retire_counter.sv
// Wrapping retired-instruction counter with enable and synchronous reset.
module pc_retire_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus req/ack instruction fetch and issue FSM.
// Optional PC_MISALIGN_TRAP_EN: misaligned pc_next traps to HALTED instead of being word-aligned.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int                   ADDR_BITS  = 32,
  parameter logic [ADDR_BITS-1:0] RESET_PC   = ADDR_BITS'(RESET_PC_DEFAULT),
  parameter int                   INSTR_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_BITS-1:0]  pc_next,
  input  logic                  stall,
  input  logic                  halt,
  output logic                  imem_req,
  output logic [ADDR_BITS-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_BITS-1:0] imem_rdata,
  output logic [ADDR_BITS-1:0]  pc,
  output logic [ADDR_BITS-1:0]  pc_plus4,
  output logic [INSTR_BITS-1:0] instr,
  output logic                  instr_valid,
  output logic                  halted,
  output logic [31:0]           retired
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);

  fetch_state_t         state;
  fetch_state_t         state_next;
  logic                 retire_en;
  logic                 pc_load;
  logic                 halt_set;
  logic                 trap_set;
  logic [ADDR_BITS-1:0] pc_target;

`ifdef PC_MISALIGN_TRAP_EN
  assign pc_target = pc_next;
`else
  // Misaligned targets are silently rounded down to the containing word.
  logic unused_pc_next_lo;
  assign unused_pc_next_lo = ^pc_next[1:0];
  assign pc_target = {pc_next[ADDR_BITS-1:2], 2'b00};
`endif

  always_comb begin
    state_next = state;
    retire_en  = 1'b0;
    pc_load    = 1'b0;
    halt_set   = 1'b0;
    trap_set   = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) state_next = ISSUE;
      end
      ISSUE: begin
        // stall outranks both halt and any retire side effect
        if (!stall) begin
          retire_en = 1'b1;
          if (halt) begin
            halt_set   = 1'b1;
            state_next = HALTED;
          end
`ifdef PC_MISALIGN_TRAP_EN
          else if (!word_aligned(pc_next[1:0])) begin
            trap_set   = 1'b1;
            halt_set   = 1'b1;
            state_next = HALTED;
          end
`endif
          else begin
            pc_load    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      halted   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if ((state == FETCH) && imem_ack) instr <= imem_rdata;
      if (pc_load) pc <= pc_target;
      if (halt_set) halted <= 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
      if (trap_set) misalign <= 1'b1;
`endif
    end
  end

`ifndef PC_MISALIGN_TRAP_EN
  logic unused_trap_set;
  assign unused_trap_set = trap_set;
`endif

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign pc_plus4    = pc + ADDR_BITS'(PC_STEP);

  pc_retire_counter #(
    .WIDTH(32)
  ) u_retire (
    .clk  (clk),
    .rst  (rst),
    .en   (retire_en),
    .count(retired)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: table of fetch/retire vectors plus hand sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        stall;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [31:0] retired;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic [31:0] nxt;
    logic [31:0] pc_before;
    logic [31:0] pc_after;
    logic [31:0] ret_after;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_next    (pc_next),
    .stall      (stall),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .halted     (halted),
    .retired    (retired)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge after retire (back in FETCH).
  task automatic do_instr(input vec_t v);
    logic [31:0] p4;
    p4 = v.pc_before + 32'd4;
    chk("fetch req", imem_req, 1);
    chk("fetch addr", imem_addr, v.pc_before);
    chk("pc_plus4", pc_plus4, p4);
    for (int w = 0; w < v.waits; w++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("wait req held", imem_req, 1);
      chk("wait addr held", imem_addr, v.pc_before);
    end
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    chk("issue valid", instr_valid, 1);
    chk("issue instr", instr, v.rdata);
    chk("issue req low", imem_req, 0);
    pc_next = v.nxt;
    @(negedge clk);
    chk("retire pc", pc, v.pc_after);
    chk("retire count", retired, v.ret_after);
    chk("retire valid low", instr_valid, 0);
    chk("refetch req", imem_req, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    pc_next    = 32'h0;
    stall      = 1'b0;
    halt       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    vecs[0] = '{2, 32'h2002_0001, 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'd1};
    vecs[1] = '{0, 32'h1111_1111, 32'h0000_0008, 32'h0000_0004, 32'h0000_0008, 32'd2};
    vecs[2] = '{0, 32'h2222_2222, 32'h0000_000C, 32'h0000_0008, 32'h0000_000C, 32'd3};
    vecs[3] = '{1, 32'h3333_3333, 32'hFFFF_FFFC, 32'h0000_000C, 32'hFFFF_FFFC, 32'd4};
    vecs[4] = '{0, 32'h4444_4444, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_0100, 32'd5};

    repeat (2) @(negedge clk);
    chk("rst req", imem_req, 0);
    chk("rst pc", pc, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst valid", instr_valid, 0);
    chk("rst halted", halted, 0);
    chk("rst retired", retired, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("rst misalign", misalign, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("pc_plus4 wrap", pc_plus4, 32'h0);
      do_instr(vecs[i]);
    end

    // stall held for three cycles with halt pending, then release
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_5555;
    @(negedge clk);
    imem_ack = 1'b0;
    stall    = 1'b1;
    halt     = 1'b1;
    pc_next  = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall valid", instr_valid, 1);
      chk("stall instr", instr, 32'h5555_5555);
      chk("stall pc", pc, 32'h0000_0100);
      chk("stall halted", halted, 0);
      chk("stall retired", retired, 32'd5);
      chk("stall req", imem_req, 0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("halt halted", halted, 1);
    chk("halt valid", instr_valid, 0);
    chk("halt req", imem_req, 0);
    chk("halt pc", pc, 32'h0000_0100);
    chk("halt retired", retired, 32'd6);
    halt     = 1'b0;
    imem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("halted sticky", halted, 1);
      chk("halted req", imem_req, 0);
      chk("halted retired", retired, 32'd6);
    end
    imem_ack = 1'b0;

    // reset lands while a fetch is outstanding; the late ack must be dropped
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("pre-rst req", imem_req, 1);
    chk("pre-rst addr", imem_addr, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    chk("midrst req", imem_req, 0);
    chk("midrst pc", pc, 32'h0);
    chk("midrst valid", instr_valid, 0);
    chk("midrst instr", instr, 32'h0);
    chk("midrst halted", halted, 0);
    chk("midrst retired", retired, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late ack ignored", instr, 32'h0);
    chk("late ack valid", instr_valid, 0);
    chk("refetch after rst", imem_req, 1);

    // retired counter wrap from all-ones
    force dut.u_retire.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_retire.count;
    chk("preload retired", retired, 32'hFFFF_FFFF);
    do_instr('{0, 32'h6666_6666, 32'h0000_0008, 32'h0000_0000, 32'h0000_0008, 32'd0});

    // misaligned pc_next
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_7777;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mis issue valid", instr_valid, 1);
    pc_next = 32'h0000_0006;
    @(negedge clk);
    chk("mis retired", retired, 32'd1);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis flag", misalign, 1);
    chk("mis halted", halted, 1);
    chk("mis pc held", pc, 32'h0000_0008);
    chk("mis req", imem_req, 0);
    chk("mis valid", instr_valid, 0);
`else
    chk("mis pc aligned", pc, 32'h0000_0004);
    chk("mis not halted", halted, 0);
    chk("mis refetch", imem_req, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
